// File: rtl/multi_channel_enable_generator_pkg.sv
// Shared definitions for the multi-channel enable generator: mode encoding,
// reset divisor derivation and channel-select width.
package multi_channel_enable_pkg;

    // Channel run mode as carried on i_cfg_oneshot and held per channel.
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Number of clk cycles in one second: the divisor a channel powers up
    // with, so an unconfigured channel behaves like the old 1 Hz enable.
    function automatic longint unsigned default_div(input longint unsigned clk_freq_hz);
        return clk_freq_hz;
    endfunction

    // Width of the channel-select field; a single channel still gets one bit
    // so the port never collapses to zero width.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/multi_channel_enable_generator_channel.sv
// One enable channel: divisor counter with shadowed divisor/mode, start/stop
// control, one-shot completion flag and a registered single-cycle strobe.
module enable_channel
    import multi_channel_enable_pkg::*;
#(
    parameter int unsigned      DIV_W     = 24,
    parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(12000000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sync,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             en,
    output logic             active,
    output logic             done
);

    logic [DIV_W-1:0] count_reg,      count_next;
    logic [DIV_W-1:0] div_reg,        div_next;
    logic [DIV_W-1:0] shadow_div_reg, shadow_div_next;
    logic             mode_reg,       mode_next;
    logic             shadow_mode_reg, shadow_mode_next;
    logic             en_reg,         en_next;
    logic             active_reg,     active_next;
    logic             done_reg,       done_next;

    logic             wrap;
    logic [DIV_W-1:0] start_div;

    // Terminal count; only meaningful while running, and div is never zero
    // while running so div-1 cannot underflow into a bogus match.
    assign wrap = active_reg && (count_reg == (div_reg - DIV_W'(1)));

    // A write landing on an idle channel in the same cycle as its start is
    // already the divisor the start will use.
    assign start_div = (cfg_wr && !active_reg) ? cfg_div : div_reg;

    // Next-state logic; priority is stop, then start, then sync, then counting.
    always_comb begin
        count_next       = count_reg;
        div_next         = div_reg;
        shadow_div_next  = shadow_div_reg;
        mode_next        = mode_reg;
        shadow_mode_next = shadow_mode_reg;
        en_next          = 1'b0;
        active_next      = active_reg;
        done_next        = done_reg;

        // Every write lands in the shadow; an idle channel also takes it live
        // because there is no period in flight to protect.
        if (cfg_wr) begin
            shadow_div_next  = cfg_div;
            shadow_mode_next = cfg_mode;
            if (!active_reg) begin
                div_next  = cfg_div;
                mode_next = cfg_mode;
            end
        end

        if (stop) begin
            // Any wrap this cycle is swallowed: no strobe after a stop.
            active_next = 1'b0;
            count_next  = '0;
        end else if (start) begin
            if (active_reg) begin
                // Restart the period; a coincident wrap produces no strobe.
                count_next = '0;
                done_next  = 1'b0;
            end else if (start_div != '0) begin
                active_next = 1'b1;
                count_next  = '0;
                done_next   = 1'b0;
            end
        end else if (active_reg) begin
            if (sync) begin
                count_next = '0;
            end else if (wrap) begin
                count_next = '0;
                en_next    = 1'b1;
                // The period just finished used the old divisor; the shadow
                // (including a write arriving this very cycle) takes over now.
                div_next   = shadow_div_next;
                mode_next  = shadow_mode_next;
                if (mode_reg == MODE_ONESHOT) begin
                    active_next = 1'b0;
                    done_next   = 1'b1;
                end else if (shadow_div_next == '0) begin
                    // A zero divisor cannot run; park the channel quietly.
                    active_next = 1'b0;
                end
            end else begin
                count_next = count_reg + DIV_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg       <= '0;
            div_reg         <= RESET_DIV;
            shadow_div_reg  <= RESET_DIV;
            mode_reg        <= MODE_PERIODIC;
            shadow_mode_reg <= MODE_PERIODIC;
            en_reg          <= 1'b0;
            active_reg      <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            count_reg       <= count_next;
            div_reg         <= div_next;
            shadow_div_reg  <= shadow_div_next;
            mode_reg        <= mode_next;
            shadow_mode_reg <= shadow_mode_next;
            en_reg          <= en_next;
            active_reg      <= active_next;
            done_reg        <= done_next;
        end
    end

    assign en     = en_reg;
    assign active = active_reg;
    assign done   = done_reg;

endmodule

// File: rtl/multi_channel_enable_generator.sv
// Common timebase: NUM_CH independent programmable enable-strobe channels
// sharing one configuration write port and a global phase-sync input.
module multi_channel_enable_generator
    import multi_channel_enable_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 24,
    localparam int         CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cfg_wr,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [DIV_W-1:0]  i_cfg_div,
    input  logic              i_cfg_oneshot,
    input  logic [NUM_CH-1:0] i_start,
    input  logic [NUM_CH-1:0] i_stop,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_en,
    output logic [NUM_CH-1:0] o_active,
    output logic [NUM_CH-1:0] o_done
);

    // Divisor every channel comes out of reset with (1 Hz).
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(default_div(CLK_FREQ_HZ));

    logic [NUM_CH-1:0] cfg_wr_ch;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Write decode: an index beyond the last channel matches nothing,
            // so such writes are dropped.
            assign cfg_wr_ch[gi] = i_cfg_wr && (i_cfg_ch == CH_W'(gi));

            enable_channel #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV)
            ) u_channel (
                .clk      (clk),
                .reset_n  (reset_n),
                .start    (i_start[gi]),
                .stop     (i_stop[gi]),
                .sync     (i_sync),
                .cfg_wr   (cfg_wr_ch[gi]),
                .cfg_div  (i_cfg_div),
                .cfg_mode (i_cfg_oneshot),
                .en       (o_en[gi]),
                .active   (o_active[gi]),
                .done     (o_done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_enable_generator.sv
// Directed bench for the enable generator with two 8-bit channels and a
// reset divisor of 10.
module tb_multi_channel_enable_generator;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int CLK_HZ = 10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             i_cfg_wr;
    logic [0:0]       i_cfg_ch;
    logic [DIV_W-1:0] i_cfg_div;
    logic             i_cfg_oneshot;
    logic [1:0]       i_start;
    logic [1:0]       i_stop;
    logic             i_sync;
    logic [1:0]       o_en;
    logic [1:0]       o_active;
    logic [1:0]       o_done;

    int total = 0;
    int bad   = 0;

    multi_channel_enable_generator #(
        .CLK_FREQ_HZ (CLK_HZ),
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_cfg_wr      (i_cfg_wr),
        .i_cfg_ch      (i_cfg_ch),
        .i_cfg_div     (i_cfg_div),
        .i_cfg_oneshot (i_cfg_oneshot),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_sync        (i_sync),
        .o_en          (o_en),
        .o_active      (o_active),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int div, input bit oneshot);
        i_cfg_wr      = 1'b1;
        i_cfg_ch      = ch[0:0];
        i_cfg_div     = div[DIV_W-1:0];
        i_cfg_oneshot = oneshot;
        tick();
        i_cfg_wr      = 1'b0;
        $display("cfg ch=%0d div=%0d oneshot=%0d", ch, div, oneshot);
    endtask

    task automatic pulse_start(input logic [1:0] mask);
        i_start = mask;
        tick();
        i_start = 2'b00;
        $display("start mask=%b", mask);
    endtask

    initial begin
        reset_n       = 1'b0;
        i_cfg_wr      = 1'b0;
        i_cfg_ch      = 1'b0;
        i_cfg_div     = '0;
        i_cfg_oneshot = 1'b0;
        i_start       = 2'b00;
        i_stop        = 2'b00;
        i_sync        = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_en", o_en, 2'b00);
        chk("rst_active", o_active, 2'b00);
        chk("rst_done", o_done, 2'b00);
        reset_n = 1'b1;
        $display("reset released");

        // ch0 periodic at reset divisor 10
        pulse_start(2'b01);
        chk("p10_start_active", o_active, 2'b01);
        chk("p10_start_en", o_en, 2'b00);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("p10_en", o_en, {1'b0, (k % 10) == 0});
        end
        $display("ch0 div=10 two periods");

        // Divisor change at count 5: old period finishes, then period 4
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("shadow_pre_en", o_en, 2'b00);
        end
        cfg(0, 4, 1'b0);
        chk("shadow_wr_en", o_en, 2'b00);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("shadow_en", o_en, {1'b0, (k % 4) == 0});
        end
        chk("shadow_active", o_active, 2'b01);

        // Stop ch0, then one-shot on ch1 with div 3
        i_stop = 2'b01;
        tick();
        i_stop = 2'b00;
        $display("stop ch0");
        chk("stop_active", o_active, 2'b00);
        cfg(1, 3, 1'b1);
        chk("os_cfg_active", o_active, 2'b00);
        pulse_start(2'b10);
        chk("os_start_active", o_active, 2'b10);
        chk("os_start_done", o_done, 2'b00);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("os_en", o_en, {k == 3, 1'b0});
            chk("os_active", o_active, {k < 3, 1'b0});
            chk("os_done", o_done, {k >= 3, 1'b0});
        end

        // Start and stop together on a running channel: stop wins
        pulse_start(2'b01);
        chk("ss_run_active", o_active, 2'b01);
        tick();
        tick();
        i_start = 2'b01;
        i_stop  = 2'b01;
        tick();
        i_start = 2'b00;
        i_stop  = 2'b00;
        $display("start+stop ch0");
        chk("ss_active", o_active, 2'b00);
        chk("ss_en", o_en, 2'b00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("ss_after_en", o_en, 2'b00);
        end

        // Sync at count 7 with div 10: next strobe 10 cycles later
        cfg(0, 10, 1'b0);
        pulse_start(2'b01);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("sync_pre_en", o_en, 2'b00);
        end
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        $display("sync");
        chk("sync_en", o_en, 2'b00);
        chk("sync_active", o_active, 2'b01);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("sync_post_en", o_en, {1'b0, k == 10});
        end

        // div=1 on ch0 (strobe every cycle) alongside a fresh ch1 one-shot
        i_stop = 2'b01;
        tick();
        i_stop = 2'b00;
        chk("d1_stop_active", o_active, 2'b00);
        cfg(0, 1, 1'b0);
        pulse_start(2'b11);
        chk("d1_start_active", o_active, 2'b11);
        chk("d1_start_done", o_done, 2'b00);
        chk("d1_start_en", o_en, 2'b00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("d1_en", o_en, {k == 3, 1'b1});
        end
        chk("d1_active", o_active, 2'b01);
        chk("d1_done", o_done, 2'b10);
        i_stop = 2'b01;
        tick();
        i_stop = 2'b00;
        chk("d1_stop_en", o_en, 2'b00);
        chk("d1_stop_active2", o_active, 2'b00);

        // div=0: start is ignored
        cfg(0, 0, 1'b0);
        pulse_start(2'b01);
        chk("d0_active", o_active, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("d0_idle_active", o_active, 2'b00);
            chk("d0_idle_en", o_en, 2'b00);
        end

        // Reset mid-count with ch1 one-shot pending
        cfg(0, 5, 1'b0);
        pulse_start(2'b11);
        chk("mr_start_active", o_active, 2'b11);
        chk("mr_start_done", o_done, 2'b00);
        tick();
        reset_n = 1'b0;
        tick();
        $display("reset asserted mid-count");
        chk("mr_en", o_en, 2'b00);
        chk("mr_active", o_active, 2'b00);
        chk("mr_done", o_done, 2'b00);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("mr_idle_en", o_en, 2'b00);
            chk("mr_idle_active", o_active, 2'b00);
        end
        pulse_start(2'b11);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("mr_resume_en", o_en, {(k % 10) == 0, (k % 10) == 0});
        end
        chk("mr_resume_active", o_active, 2'b11);
        chk("mr_resume_done", o_done, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
